// File: rtl/window_accum.sv
// Sums each non-overlapping window of WINDOW signed samples into one widened result.
// Define WINACC_MEAN_EN to emit the window mean (floor) instead of the sum.
module window_accum #(
    parameter int unsigned WORDSIZE = 8,
    parameter int unsigned WINDOW   = 4,
    parameter int unsigned ACCW     = WORDSIZE + $clog2(WINDOW)
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic [WORDSIZE-1:0]       iData,
    input  logic                      iValid,
    output logic                      oReady,
    output logic [ACCW-1:0]           oData,
    output logic                      oValid,
    input  logic                      iReady,
    output logic [$clog2(WINDOW)-1:0] oCount
);

    localparam int unsigned CW = $clog2(WINDOW);
    localparam logic [CW-1:0] LastCount = CW'(WINDOW - 1);

    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [ACCW-1:0] data_q, data_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   valid_q, valid_d;

    logic signed [ACCW-1:0] sample_ext;
    logic signed [ACCW-1:0] sum;
    logic signed [ACCW-1:0] result;
    logic                   is_last;
    logic                   accept;
    logic                   fire;

    assign sample_ext = {{(ACCW - WORDSIZE){iData[WORDSIZE-1]}}, iData};
    assign sum        = acc_q + sample_ext;

`ifdef WINACC_MEAN_EN
    // Arithmetic shift keeps the sign, so the mean rounds toward -inf.
    assign result = sum >>> CW;
`else
    assign result = sum;
`endif

    assign is_last = (count_q == LastCount);
    // Only the closing sample stalls, and only while the held result is not draining.
    assign oReady  = !(is_last && valid_q && !iReady);
    assign accept  = iValid && oReady;
    assign fire    = accept && is_last;

    always_comb begin
        acc_d   = acc_q;
        data_d  = data_q;
        count_d = count_q;
        valid_d = valid_q;

        if (valid_q && iReady) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            if (is_last) begin
                acc_d   = '0;
                count_d = '0;
                data_d  = result;
                valid_d = 1'b1;
            end else begin
                acc_d   = sum;
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            acc_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            data_q  <= data_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign oData  = data_q;
    assign oValid = valid_q;
    assign oCount = count_q;

    logic unused_fire;
    assign unused_fire = fire;

endmodule

// File: tb/tb_window_accum.sv
// Directed bench for window_accum (WORDSIZE=8, WINDOW=4, ACCW=10).
// Expected window results follow WINACC_MEAN_EN when it is defined.
module tb_window_accum;

    localparam int unsigned WORDSIZE = 8;
    localparam int unsigned WINDOW   = 4;
    localparam int unsigned ACCW     = 10;

    logic                iClk = 1'b0;
    logic                iRst;
    logic [WORDSIZE-1:0] iData;
    logic                iValid;
    logic                oReady;
    logic [ACCW-1:0]     oData;
    logic                oValid;
    logic                iReady;
    logic [1:0]          oCount;

    int tests = 0;
    int fails = 0;

    window_accum #(
        .WORDSIZE(WORDSIZE),
        .WINDOW  (WINDOW),
        .ACCW    (ACCW)
    ) dut (
        .iClk  (iClk),
        .iRst  (iRst),
        .iData (iData),
        .iValid(iValid),
        .oReady(oReady),
        .oData (oData),
        .oValid(oValid),
        .iReady(iReady),
        .oCount(oCount)
    );

    always #5 iClk = ~iClk;

    function automatic int res(input int s);
`ifdef WINACC_MEAN_EN
        return s >>> 2;
`else
        return s;
`endif
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One accepted-or-offered sample; returns #1 after the edge with iValid low.
    task automatic send(input int d);
        iValid = 1'b1;
        iData  = WORDSIZE'(d);
        @(posedge iClk);
        #1;
        iValid = 1'b0;
    endtask

    task automatic idle();
        @(posedge iClk);
        #1;
    endtask

    initial begin
        iRst   = 1'b1;
        iValid = 1'b0;
        iData  = '0;
        iReady = 1'b1;
        #2;
        chk("reset_valid", oValid, 0);
        chk("reset_data", $signed(oData), 0);
        chk("reset_count", oCount, 0);
        chk("reset_ready", oReady, 1);
        @(posedge iClk);
        @(posedge iClk);
        #1;
        iRst = 1'b0;

        // Basic window
        send(10);
        send(20);
        chk("basic_count2", oCount, 2);
        send(30);
        chk("basic_no_early_valid", oValid, 0);
        send(40);
        chk("basic_valid", oValid, 1);
        chk("basic_data", $signed(oData), res(100));
        chk("basic_count_wrap", oCount, 0);
        idle();
        chk("basic_one_cycle", oValid, 0);

        // Extremes
        repeat (4) send(-128);
        chk("min_data", $signed(oData), res(-512));
        repeat (4) send(127);
        chk("max_data", $signed(oData), res(508));
        send(-3); send(0); send(0); send(0);
        chk("neg_small", $signed(oData), res(-3));
        send(10); send(20); send(30); send(41);
        chk("odd_sum", $signed(oData), res(101));
        idle();

        // Back-pressure
        iReady = 1'b0;
        repeat (4) send(1);
        chk("bp_w1_valid", oValid, 1);
        chk("bp_w1_data", $signed(oData), res(4));
        repeat (3) send(2);
        chk("bp_partial_count", oCount, 3);
        chk("bp_hold_data", $signed(oData), res(4));
        iValid = 1'b1;
        iData  = 8'd2;
        #1;
        chk("bp_stall_ready", oReady, 0);
        @(posedge iClk);
        #1;
        chk("bp_stall_count", oCount, 3);
        chk("bp_stall_valid", oValid, 1);
        chk("bp_stall_data", $signed(oData), res(4));
        iReady = 1'b1;
        #1;
        chk("bp_release_ready", oReady, 1);
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        chk("bp_swap_valid", oValid, 1);
        chk("bp_swap_data", $signed(oData), res(8));
        chk("bp_swap_count", oCount, 0);
        idle();
        chk("bp_drained", oValid, 0);

        // Bubbles
        send(5);
        idle();
        chk("bub_idle1", oCount, 1);
        send(6);
        idle();
        chk("bub_idle2", oCount, 2);
        send(7);
        idle();
        chk("bub_idle3", oCount, 3);
        chk("bub_no_valid", oValid, 0);
        send(8);
        chk("bub_valid", oValid, 1);
        chk("bub_data", $signed(oData), res(26));
        idle();

        // Reset mid-operation with a pending result
        iReady = 1'b0;
        repeat (4) send(9);
        send(1); send(2); send(3);
        chk("rst_pre_valid", oValid, 1);
        chk("rst_pre_count", oCount, 3);
        #3;
        iRst = 1'b1;
        #1;
        chk("rst_async_valid", oValid, 0);
        chk("rst_async_data", $signed(oData), 0);
        chk("rst_async_count", oCount, 0);
        #2;
        iRst   = 1'b0;
        iReady = 1'b1;
        @(posedge iClk);
        #1;
        send(1); send(2); send(3); send(4);
        chk("rst_after_data", $signed(oData), res(10));
        chk("rst_after_valid", oValid, 1);

        // Continuous stream 0..11
        for (int i = 0; i < 12; i++) begin
            iValid = 1'b1;
            iData  = WORDSIZE'(i);
            #1;
            chk("cont_ready", oReady, 1);
            @(posedge iClk);
            #1;
            if (i % 4 == 3) begin
                chk("cont_valid", oValid, 1);
                chk("cont_data", $signed(oData), res(6 + 16 * (i / 4)));
            end
        end
        iValid = 1'b0;
        idle();
        chk("cont_drained", oValid, 0);
        chk("cont_count", oCount, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
